// File: rtl/ptp_tsq_multi.sv
`timescale 1ns/1ps
// ptp_tsq_multi: per-channel PTP timestamp FIFOs with a host register window
// for popping {info, sec, ns} snapshots and monitoring overflow.
module ptp_tsq_multi #(
    parameter int CHANNELS    = 2,
    parameter int DEPTH_LOG2  = 4,
    parameter int DROP_OLDEST = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    ts_valid,
    input  logic [CHANNELS*48-1:0] ts_sec,
    input  logic [CHANNELS*32-1:0] ts_ns,
    input  logic [CHANNELS*16-1:0] ts_info,
    input  logic                   wr_in,
    input  logic                   rd_in,
    input  logic [7:0]             addr_in,
    input  logic [31:0]            data_in,
    output logic [31:0]            data_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [4:0]  off;
    logic [31:0] rv [8];
    logic        unused_data;

    assign off         = addr_in[4:0];
    assign unused_data = ^data_in[31:3];

    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < CHANNELS) begin : g_on
            logic [95:0]           mem [DEPTH];
            logic [95:0]           snap;
            logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
            logic [CW-1:0]         count;
            logic [7:0]            drop;
            logic                  ovf_flag, snap_valid;
            logic                  sel, flush, clr, pop, full, empty, pop_ok, ovf, push, adv_rd;
            logic [31:0]           status;

            always_comb begin
                sel    = wr_in && addr_in[7:5] == 3'(c) && off == 5'h04;
                flush  = sel && data_in[0];
                clr    = sel && data_in[1];
                pop    = sel && data_in[2];
                full   = count == CW'(DEPTH);
                empty  = count == '0;
                pop_ok = pop && !empty;
                // a full queue only overflows when no pop frees a slot this cycle
                ovf    = ts_valid[c] && !flush && full && !pop_ok;
                push   = ts_valid[c] && !flush && (!ovf || DROP_OLDEST != 0);
                adv_rd = pop_ok || (ovf && DROP_OLDEST != 0);
                status = {drop, 4'b0, snap_valid, ovf_flag, full, empty, 7'b0, 9'(count)};
            end

            always_ff @(posedge clk)
                if (push) mem[wr_ptr] <= {ts_info[c*16 +: 16], ts_sec[c*48 +: 48], ts_ns[c*32 +: 32]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    count      <= '0;
                    snap       <= '0;
                    snap_valid <= 1'b0;
                    ovf_flag   <= 1'b0;
                    drop       <= '0;
                end else begin
                    if (flush) begin
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        count      <= '0;
                        snap_valid <= 1'b0;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                        if (adv_rd) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                        count <= count + CW'(push) - CW'(adv_rd);
                        if (pop) snap_valid <= pop_ok;
                        if (pop_ok) snap <= mem[rd_ptr];
                    end
                    if (clr) begin
                        ovf_flag <= 1'b0;
                        drop     <= '0;
                    end else if (ovf) begin
                        ovf_flag <= 1'b1;
                        if (drop != 8'hff) drop <= drop + 8'd1;
                    end
                end
            end

            assign rv[c] = off == 5'h00 ? status :
                           off == 5'h08 ? snap[95:64] :
                           off == 5'h0c ? snap[63:32] :
                           off == 5'h10 ? snap[31:0] : '0;
        end else begin : g_off
            assign rv[c] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) data_out <= '0;
        else if (rd_in) data_out <= rv[addr_in[7:5]];
endmodule
